// File: rtl/keypad_pkg.sv
// Shared types, defaults and key map for the 4x4 keypad scanner.
package keypad_pkg;

   localparam int unsigned SCAN_DIV_DEFAULT = 4;
   localparam int unsigned DEBOUNCE_DEFAULT = 8;

   typedef enum logic [2:0] {
      SCAN       = 3'd0,
      PRESS_DB   = 3'd1,
      VALID      = 3'd2,
      HOLD       = 3'd3,
      RELEASE_DB = 3'd4
   } state_e;

   // Indexed by {row, col}; entry 0 is row 0 / col 0.
   localparam logic [15:0][3:0] KEY_MAP = {
      4'hD, 4'hF, 4'h0, 4'hE,
      4'hC, 4'h9, 4'h8, 4'h7,
      4'hB, 4'h6, 4'h5, 4'h4,
      4'hA, 4'h3, 4'h2, 4'h1
   };

   function automatic logic one_low(input logic [3:0] r);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 4; i++) begin
         if (!r[i]) n = n + 3'd1;
      end
      return (n == 3'd1);
   endfunction

   function automatic logic [1:0] low_idx(input logic [3:0] r);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!r[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous inputs; flops reset to all ones.
module keypad_sync #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce, one strobe per key.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV        = SCAN_DIV_DEFAULT,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic       v,
   output logic [3:0] code,
   output logic       key_held
);

   localparam int unsigned CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
   localparam int unsigned CW      = $clog2(CNT_MAX) + 1;

   logic [3:0]    row_s;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    col_idx_q, col_idx_d;
   logic [3:0]    row_lat_q, row_lat_d;
   logic [3:0]    col_q, col_d;
   logic [3:0]    code_q, code_d;
   logic          v_q, v_d;
   logic          key_held_q, key_held_d;

   keypad_sync #(.WIDTH(4)) u_sync (
      .clock (clock),
      .reset (reset),
      .d     (row),
      .q     (row_s)
   );

   // Next state; outputs are computed from the next state so they line up with state_q.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      col_idx_d  = col_idx_q;
      row_lat_d  = row_lat_q;
      code_d     = code_q;

      case (state_q)
         SCAN: begin
            if (cnt_q >= CW'(SCAN_DIV - 1)) begin
               cnt_d = '0;
               if (one_low(row_s)) begin
                  state_d   = PRESS_DB;
                  row_lat_d = row_s;
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PRESS_DB: begin
            if (row_s != row_lat_q) begin
               state_d   = SCAN;
               cnt_d     = '0;
               col_idx_d = col_idx_q + 2'd1;
            end else if (cnt_q >= CW'(DEBOUNCE_CYCLES - 1)) begin
               state_d = VALID;
               cnt_d   = '0;
               code_d  = KEY_MAP[{low_idx(row_lat_q), col_idx_q}];
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         VALID: begin
            state_d = HOLD;
            cnt_d   = '0;
         end
         HOLD: begin
            // The all-ones cycle seen here is the first of the release run.
            if (row_s == 4'hF) begin
               state_d = RELEASE_DB;
               cnt_d   = CW'(1);
            end
         end
         RELEASE_DB: begin
            if (row_s != 4'hF) begin
               state_d = HOLD;
               cnt_d   = '0;
            end else if (cnt_q >= CW'(DEBOUNCE_CYCLES - 1)) begin
               state_d   = SCAN;
               cnt_d     = '0;
               col_idx_d = col_idx_q + 2'd1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = SCAN;
            cnt_d   = '0;
         end
      endcase

      v_d        = (state_d == VALID);
      key_held_d = (state_d == VALID) || (state_d == HOLD) || (state_d == RELEASE_DB);
      col_d      = ~(4'b0001 << col_idx_d);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= SCAN;
         cnt_q      <= '0;
         col_idx_q  <= 2'd0;
         row_lat_q  <= 4'hF;
         col_q      <= 4'b1110;
         code_q     <= 4'h0;
         v_q        <= 1'b0;
         key_held_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         col_idx_q  <= col_idx_d;
         row_lat_q  <= row_lat_d;
         col_q      <= col_d;
         code_q     <= code_d;
         v_q        <= v_d;
         key_held_q <= key_held_d;
      end
   end

   assign col      = col_q;
   assign v        = v_q;
   assign code     = code_q;
   assign key_held = key_held_q;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles each column is driven before its rows are sampled.
REQ-002 Parameter DEBOUNCE_CYCLES, default 8: consecutive identical samples required for press and for release.
REQ-003 clock  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 row  input  4  keypad row lines, active-low, pulled up externally, asynchronous to clock.
REQ-006 col  output  4  keypad column drive, active-low one-hot (exactly one bit low at all times).
REQ-007 v  output  1  one-cycle key-valid strobe to the downstream controller.
REQ-008 code  output  4  encoded key value; valid when v=1, held until the next strobe.
REQ-009 key_held  output  1  high while an accepted key remains pressed.

Function
REQ-010 row SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value row_s.
REQ-011 FSM states SHALL be SCAN, PRESS_DB, VALID, HOLD, RELEASE_DB.
REQ-012 SCAN: drive column k low for SCAN_DIV cycles, sample row_s on the last cycle, then advance k (3 wraps to 0).
- Sample with exactly one row_s bit low: latch row/column, go PRESS_DB, freeze col.
- Zero or more than one bit low (none/ghost): keep scanning.
REQ-013 PRESS_DB: count cycles in which row_s equals the latched pattern.
- Mismatch: return to SCAN at column k+1.
- DEBOUNCE_CYCLES consecutive matches: go VALID.
REQ-014 VALID: lasts exactly one cycle; v=1 and code updated in that same cycle; then go HOLD.
REQ-015 HOLD: col stays frozen; on the first cycle row_s is all-ones, go RELEASE_DB.
REQ-016 RELEASE_DB: count consecutive all-ones cycles.
- Any low bit: return to HOLD.
- DEBOUNCE_CYCLES consecutive all-ones: go SCAN at column k+1.
REQ-017 A held key SHALL produce exactly one v pulse; no auto-repeat.
REQ-018 Key code map, row r / col c:
- r0 = 1,2,3,A
- r1 = 4,5,6,B
- r2 = 7,8,9,C
- r3 = E(*),0,F(#),D
- Encoded as hex nibble 0x1,0x2,0x3,0xA / 0x4,0x5,0x6,0xB / 0x7,0x8,0x9,0xC / 0xE,0x0,0xF,0xD.
REQ-019 key_held SHALL be 1 in VALID, HOLD and RELEASE_DB, 0 otherwise.
REQ-020 The scanner SHALL NOT observe FIFO full; overflow handling belongs to the downstream controller.
REQ-021 Counters SHALL be sized ceil(log2(max(SCAN_DIV,DEBOUNCE_CYCLES)))+1 bits and never wrap.

Reset
REQ-022 While reset=1 outputs SHALL be:
- state = SCAN
- col = 4'b1110
- v = 0
- code = 4'h0
- key_held = 0
- all counters and synchronizer flops reset (synchronizer flops to 1).
REQ-023 Reset asserted mid-debounce or mid-hold SHALL abort without a v pulse; scanning restarts at column 0 after deassertion.

Structure
REQ-024 A shared package keypad_pkg SHALL hold the state enum, the 16-entry code map constant, and the default SCAN_DIV/DEBOUNCE_CYCLES values.
REQ-025 The synchronizer SHALL be a separate sub-module keypad_sync (parameterised width, async active-high reset).

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8, keypad model drives row from pressed key and col)
REQ-026 Reset check: reset=1 asynchronously mid-cycle -> col=1110, v=0, code=0 immediately.
REQ-027 Key '5' (r1,c1) held 200 cycles -> exactly one v pulse with code=0x5; key_held=1 until DEBOUNCE_CYCLES+2 cycles after release.
REQ-028 Bounce: '#' (r3,c2) toggled every 3 cycles for 30 cycles, then stable -> no v during bouncing; one v with code=0xF after it settles.
REQ-029 Ghost: keys '1' and '4' (same column c0) pressed together -> no v; releasing '4' -> v with code=0x1.
REQ-030 Release bounce: 'D' accepted, then released with 2 glitch lows inside the release window -> no second v; scan resumes at column 0 (wrap from column 3).
REQ-031 Reset mid-operation: reset pulsed during PRESS_DB for '0' -> no v, col=1110; after deassertion with key still held -> v with code=0x0.
